fq_sched: RTL

//   Shares one frequency-divider datapath between N_REQ requesters. Arbitrates

---
 rtl/fq_sched_pkg.sv | 19 +
 rtl/fq_sched_if.sv | 27 ++
 rtl/fq_rr_arb.sv | 33 +++
 rtl/fq_sched.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fq_sched_pkg.sv
// Shared types and defaults for the fq_sched divided-clock scheduler.
// FSM state encoding, default parameters, and an index-wrap helper.
package fq_sched_pkg;

  localparam int DEF_CNT_LEN = 8;
  localparam int DEF_N_REQ   = 4;
  localparam int DEF_HOLD    = 4;
  localparam int PER_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01
  } state_e;

  function automatic int nxt_idx(int idx, int n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fq_sched_if.sv
// Requester/scheduler bundle: req, div_in in; grant, ack, busy,
// div_out, clk_out, tick out. master = clients, slave = scheduler.
interface fq_sched_if #(
  parameter int CNT_LEN = 8,
  parameter int N_REQ   = 4
);

  logic [N_REQ-1:0]         req;
  logic [N_REQ*CNT_LEN-1:0] div_in;
  logic [N_REQ-1:0]         grant;
  logic                     ack;
  logic                     busy;
  logic [CNT_LEN-1:0]       div_out;
  logic                     clk_out;
  logic                     tick;

  modport master (
    output req, div_in,
    input  grant, ack, busy, div_out, clk_out, tick
  );

  modport slave (
    input  req, div_in,
    output grant, ack, busy, div_out, clk_out, tick
  );

endinterface

// File: rtl/fq_rr_arb.sv
// Combinational round-robin pick: first req at or above ptr_i (wrapping).
// Ports: req_i, ptr_i in; win_o (one-hot), idx_o, any_o out.
import fq_sched_pkg::*;

module fq_rr_arb #(
  parameter int  N_REQ = DEF_N_REQ,
  localparam int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_REQ-1:0] win_o,
  output logic [PW-1:0]    idx_o,
  output logic             any_o
);

  logic [PW-1:0] j;

  always_comb begin
    win_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = PW'((int'(ptr_i) + k) % N_REQ);
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        win_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/fq_sched.sv
// Shared frequency divider: round-robin owner, latched ratio, clk_out/tick,
// owner/ratio switches only at period boundaries. Ports: clk, rst, bus.
import fq_sched_pkg::*;

module fq_sched #(
  parameter int CNT_LEN      = DEF_CNT_LEN,
  parameter int N_REQ        = DEF_N_REQ,
  parameter int HOLD_PERIODS = DEF_HOLD
) (
  input  logic       clk,
  input  logic       rst,
  fq_sched_if.slave  bus
);

  localparam int PW = $clog2(N_REQ);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic [CNT_LEN-1:0] div_q, div_d;
  logic               clk_q, clk_d;
  logic               tick_q, tick_d;
  logic [CNT_LEN-1:0] cnt_q, cnt_d;
  logic [PER_W-1:0]   per_q, per_d;
  logic [PW-1:0]      ptr_q, ptr_d;

  logic [N_REQ-1:0]   arb_win;
  logic [PW-1:0]      arb_idx;
  logic               arb_any;
  logic [CNT_LEN-1:0] div_sel;
  logic [CNT_LEN-1:0] div_new;
  logic               own_req;
  logic               others;
  logic               hold_ok;
  logic               take;

  fq_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .win_o (arb_win),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    div_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_idx == PW'(i))
        div_sel = bus.div_in[i*CNT_LEN +: CNT_LEN];
    end
  end

  // A zero ratio would never let cnt reach div; run it as 1.
  assign div_new = (div_sel == '0) ? CNT_LEN'(1) : div_sel;

  assign own_req = |(bus.req & grant_q);
  assign others  = |(bus.req & ~grant_q);
  assign hold_ok = (HOLD_PERIODS == 0)
                || (int'(per_q) + 1 < HOLD_PERIODS)
                || !others;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = 1'b0;
    busy_d  = busy_q;
    div_d   = div_q;
    clk_d   = clk_q;
    tick_d  = 1'b0;
    cnt_d   = cnt_q;
    per_d   = per_q;
    ptr_d   = ptr_q;
    take    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        clk_d = 1'b0;
        if (arb_any) take = 1'b1;
      end
      ST_RUN: begin
        if (cnt_q != div_q) begin
          cnt_d = cnt_q + 1'b1;
        end else if (clk_q) begin
          clk_d  = 1'b0;
          tick_d = 1'b1;
          cnt_d  = CNT_LEN'(1);
        end else if (own_req && hold_ok) begin
          // Period boundary, owner keeps the divider.
          clk_d  = 1'b1;
          tick_d = 1'b1;
          cnt_d  = CNT_LEN'(1);
          if (per_q != '1) per_d = per_q + 1'b1;
        end else if (arb_any) begin
          take = 1'b1;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          clk_d   = 1'b0;
          cnt_d   = '0;
          per_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (take) begin
      state_d = ST_RUN;
      grant_d = arb_win;
      ack_d   = 1'b1;
      busy_d  = 1'b1;
      div_d   = div_new;
      clk_d   = 1'b1;
      tick_d  = 1'b1;
      cnt_d   = CNT_LEN'(1);
      per_d   = '0;
      ptr_d   = PW'(nxt_idx(int'(arb_idx), N_REQ));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      div_q   <= '0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      cnt_q   <= '0;
      per_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      div_q   <= div_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.ack     = ack_q;
  assign bus.busy    = busy_q;
  assign bus.div_out = div_q;
  assign bus.clk_out = clk_q;
  assign bus.tick    = tick_q;

endmodule
